cpu_stage_ctrl: RTL and testbench
=================================

Name: cpu_stage_ctrl

Overview:
- Multi-cycle control sequencer for the single-issue 32-bit CPU datapath.
- Replaces the free-running clk/pc_clk pair.
- Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Emits one-cycle write enables for PC, IR, register file and data memory.
- Holds in MEMORY on a ready handshake; provides run/step/halt control and retire/cycle counters for debug.

Parameters:
- TIMEOUT_W, 4: width of the memory-wait timeout counter. Timeout fires after 2^TIMEOUT_W-1 wait cycles.
- CNT_W, 32: width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; while 1, instructions execute back to back.
- step  in  1  pulse; in IDLE with run=0, executes exactly one instruction.
- reg_wrt_sig  in  1  decoder: instruction writes the register file.
- mem_read_sig  in  1  decoder: load.
- mem_wrt_sig  in  1  decoder: store.
- branch_sig  in  1  decoder: conditional branch.
- jump_sig  in  1  decoder: jump.
- zf  in  1  ALU zero flag, valid in EXECUTE.
- mem_ready  in  1  data memory has completed the access.
- ir_en  out  1  IR load enable.
- pc_en  out  1  PC load enable.
- pc_sel  out  2  PC source: 0 = pc+4, 1 = branch target, 2 = jump target.
- reg_wrt_en  out  1  register-file write enable.
- mem_read_en  out  1  data memory read request.
- mem_wrt_en  out  1  data memory write request.
- state  out  3  current stage, for debug.
- busy  out  1  state is neither IDLE nor ERROR.
- mem_err  out  1  sticky memory-timeout error.
- cycle_cnt  out  CNT_W  cycles spent outside IDLE.
- retired_cnt  out  CNT_W  completed instructions.

Behaviour:
- Reset:
  - state=IDLE.
  - All enables 0, pc_sel=0, mem_err=0, counters 0.
  - Latched decode flags and timeout counter cleared.
  - Reset mid-instruction abandons it: no pc_en, no retire.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=7.
- Outputs are Moore-decoded from the state register plus flags latched in DECODE.
- IDLE:
  - Go to FETCH if run=1 or step=1.
  - A step pulse is latched as step_mode for that one instruction.
- FETCH: ir_en=1 for one cycle, then DECODE.
- DECODE:
  - Latch reg_wrt_sig, mem_read_sig, mem_wrt_sig, branch_sig and jump_sig.
  - Later decoder changes are ignored until the next DECODE.
  - If mem_read_sig and mem_wrt_sig are both 1, treat the instruction as a load only.
- EXECUTE:
  - Compute pc_sel: 2 if jump; else 1 if branch and zf; else 0. Jump has priority.
  - If load or store, go to MEMORY.
  - Else if reg_wrt, go to WRITEBACK.
  - Else this is the last cycle.
- MEMORY:
  - mem_read_en or mem_wrt_en is held high every cycle until a cycle with mem_ready=1.
  - Access completes in that cycle. Load goes to WRITEBACK; store ends the instruction.
  - mem_ready=1 in the first MEMORY cycle means zero wait states.
  - The timeout counter increments per cycle with mem_ready=0. On reaching all-ones, set mem_err and go to ERROR with no pc_en.
- WRITEBACK: reg_wrt_en=1 for one cycle; last cycle.
- Last cycle of every instruction:
  - pc_en=1 with pc_sel held from EXECUTE.
  - retired_cnt increments. Wrap-around is modulo 2^CNT_W.
  - Next state is FETCH if run=1 and step_mode=0, else IDLE; step_mode clears.
- run dropping mid-instruction completes the current instruction, then enters IDLE.
- ERROR:
  - Absorbing; all enables 0.
  - Exited only by rst.
- Counters: cycle_cnt increments in every state except IDLE and ERROR.
- Latency: branch/jump 3 cycles; ALU 4; store 4+w; load 5+w, where w is the number of MEMORY wait cycles.
- At most one of reg_wrt_en, mem_read_en, mem_wrt_en, ir_en is high in any cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - State encoding constants (S_IDLE..S_ERROR).
  - PC_SEL_SEQ/BRANCH/JUMP constants.
  - Default TIMEOUT_W and CNT_W.
- One natural sub-module, stage_counters: cycle_cnt and retired_cnt, driven by busy and a retire pulse.
- FSM and timeout logic stay in cpu_stage_ctrl.

Test Plan:
- ALU instruction, run=1:
  - Inputs: reg_wrt_sig=1, others 0.
  - Expect state sequence 1,2,3,5.
  - reg_wrt_en high in cycle 4; pc_en with pc_sel=0 in cycle 4; retired_cnt=1; FETCH again in cycle 5.
- Load with mem_ready low for 2 cycles:
  - mem_read_en high exactly 3 cycles, then WRITEBACK.
  - Total 7 cycles; cycle_cnt=7 after one instruction with run then dropped.
- Branch and jump:
  - branch_sig=1, zf=1: pc_sel=1, pc_en in cycle 3, no reg/mem enables.
  - branch_sig=1, zf=0: pc_sel=0.
  - jump_sig=1 with branch_sig=1, zf=1: pc_sel=2.
- Step mode:
  - run=0, one-cycle step pulse on a store with mem_ready=1: exactly one instruction of 4 cycles, then IDLE.
  - retired_cnt=1; a further step executes one more.
- Timeout with TIMEOUT_W=4 and mem_ready held 0:
  - After 15 wait cycles, mem_err=1 and state=7.
  - No pc_en; stays in ERROR despite run=1; rst returns IDLE with mem_err=0.
- Reset mid-MEMORY and decode race:
  - rst asserted during a load wait: next cycle state=0, all enables 0, counters 0.
  - Changing decoder inputs after DECODE does not alter the path taken.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer.
// Contents:
//   S_IDLE..S_ERROR  : stage encodings, also driven on the debug 'state' output
//   PC_SEL_*         : PC source select codes
//   *_DEF            : default widths for the timeout and debug counters
//   dec_flags_t      : decoder flags captured in DECODE
//   is_busy()        : true for every stage except IDLE and ERROR
package cpu_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  localparam int TIMEOUT_W_DEF = 4;
  localparam int CNT_W_DEF     = 32;

  // 'store' is already cleared when the decoder also flags a load, so the
  // rest of the sequencer never sees both set at once.
  typedef struct packed {
    logic reg_wrt;
    logic load;
    logic store;
    logic branch;
    logic jump;
  } dec_flags_t;

  function automatic logic is_busy(input logic [2:0] s);
    return (s != S_IDLE) && (s != S_ERROR);
  endfunction

endpackage

// File: rtl/stage_counters.sv
// Debug counters for the stage sequencer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   busy         : count this cycle in cycle_cnt
//   retire       : one-cycle pulse on the last cycle of an instruction
//   cycle_cnt    : cycles spent outside IDLE/ERROR
//   retired_cnt  : completed instructions (wraps modulo 2^CNT_W)
module stage_counters
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index 0 counts busy cycles, index 1 counts retired instructions.
  logic [1:0] inc;
  assign inc = {retire, busy};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (inc[gi]) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign cycle_cnt   = g_cnt[0].cnt_reg;
  assign retired_cnt = g_cnt[1].cnt_reg;

endmodule

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle control sequencer for the single-issue 32-bit CPU datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and
// emits one-cycle load/write enables.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   run, step                 : run level / single-instruction step pulse
//   reg_wrt_sig..jump_sig     : decoder outputs, captured in DECODE
//   zf                        : ALU zero flag, used in EXECUTE
//   mem_ready                 : data memory access complete
//   ir_en, pc_en, pc_sel      : IR / PC load controls
//   reg_wrt_en                : register-file write enable
//   mem_read_en, mem_wrt_en   : data memory requests
//   state, busy, mem_err      : debug status, sticky timeout error
//   cycle_cnt, retired_cnt    : debug counters
module cpu_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             reg_wrt_sig,
  input  logic             mem_read_sig,
  input  logic             mem_wrt_sig,
  input  logic             branch_sig,
  input  logic             jump_sig,
  input  logic             zf,
  input  logic             mem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             reg_wrt_en,
  output logic             mem_read_en,
  output logic             mem_wrt_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [TIMEOUT_W-1:0] TO_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] TO_ALL  = '1;
  // The wait cycle that would bring the counter to all-ones is the one
  // that trips the timeout.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_ALL - TO_ONE;

  logic [2:0]           state_reg, state_next;
  dec_flags_t           flags_reg;
  logic                 step_mode_reg;
  logic [1:0]           pc_sel_reg;
  logic [TIMEOUT_W-1:0] timeout_reg;
  logic                 mem_err_reg;

  logic       last_cycle;
  logic       timeout_hit;
  logic [1:0] exec_sel;
  logic [2:0] finish_state;

  // PC source for the current instruction; jump wins over branch.
  always_comb begin
    exec_sel = PC_SEL_SEQ;
    if (flags_reg.jump) begin
      exec_sel = PC_SEL_JUMP;
    end else if (flags_reg.branch && zf) begin
      exec_sel = PC_SEL_BRANCH;
    end
  end

  assign timeout_hit  = (state_reg == S_MEMORY) && !mem_ready && (timeout_reg == TO_LAST);
  assign finish_state = (run && !step_mode_reg) ? S_FETCH : S_IDLE;

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      flags_reg     <= '0;
      step_mode_reg <= 1'b0;
      pc_sel_reg    <= PC_SEL_SEQ;
      timeout_reg   <= '0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        flags_reg.reg_wrt <= reg_wrt_sig;
        flags_reg.load    <= mem_read_sig;
        flags_reg.store   <= mem_wrt_sig && !mem_read_sig;
        flags_reg.branch  <= branch_sig;
        flags_reg.jump    <= jump_sig;
      end
      if ((state_reg == S_IDLE) && (run || step)) begin
        step_mode_reg <= step;
      end else if (last_cycle) begin
        step_mode_reg <= 1'b0;
      end
      if (state_reg == S_EXECUTE) begin
        pc_sel_reg <= exec_sel;
      end
      // Counter only runs during MEMORY; any other stage re-arms it.
      if (state_reg == S_MEMORY) begin
        if (!mem_ready) begin
          timeout_reg <= timeout_reg + TO_ONE;
        end
      end else begin
        timeout_reg <= '0;
      end
      if (timeout_hit) begin
        mem_err_reg <= 1'b1;
      end
    end
  end

  // Next-state logic; last_cycle also drives pc_en and the retire pulse.
  always_comb begin
    state_next = state_reg;
    last_cycle = 1'b0;
    case (state_reg)
      S_IDLE:    if (run || step) state_next = S_FETCH;
      S_FETCH:   state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (flags_reg.load || flags_reg.store) begin
          state_next = S_MEMORY;
        end else if (flags_reg.reg_wrt) begin
          state_next = S_WRITEBACK;
        end else begin
          last_cycle = 1'b1;
          state_next = finish_state;
        end
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (flags_reg.load) begin
            state_next = S_WRITEBACK;
          end else begin
            last_cycle = 1'b1;
            state_next = finish_state;
          end
        end else if (timeout_hit) begin
          state_next = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        last_cycle = 1'b1;
        state_next = finish_state;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ir_en       = 1'b0;
    reg_wrt_en  = 1'b0;
    mem_read_en = 1'b0;
    mem_wrt_en  = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    case (state_reg)
      S_FETCH:     ir_en = 1'b1;
      S_EXECUTE:   pc_sel = exec_sel;
      S_MEMORY: begin
        mem_read_en = flags_reg.load;
        mem_wrt_en  = flags_reg.store;
        pc_sel      = pc_sel_reg;
      end
      S_WRITEBACK: begin
        reg_wrt_en = 1'b1;
        pc_sel     = pc_sel_reg;
      end
      default: ;
    endcase
  end

  assign pc_en   = last_cycle;
  assign state   = state_reg;
  assign busy    = is_busy(state_reg);
  assign mem_err = mem_err_reg;

  stage_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .retire     (last_cycle),
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
  );

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
module tb_cpu_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic        reg_wrt_sig, mem_read_sig, mem_wrt_sig, branch_sig, jump_sig, zf, mem_ready;
  logic        ir_en, pc_en, reg_wrt_en, mem_read_en, mem_wrt_en, busy, mem_err;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, retired_cnt;
  logic [4:0]  en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign en = {ir_en, pc_en, reg_wrt_en, mem_read_en, mem_wrt_en};

  cpu_stage_ctrl #(.TIMEOUT_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .reg_wrt_sig(reg_wrt_sig), .mem_read_sig(mem_read_sig), .mem_wrt_sig(mem_wrt_sig),
    .branch_sig(branch_sig), .jump_sig(jump_sig), .zf(zf), .mem_ready(mem_ready),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .reg_wrt_en(reg_wrt_en),
    .mem_read_en(mem_read_en), .mem_wrt_en(mem_wrt_en), .state(state), .busy(busy),
    .mem_err(mem_err), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    reg_wrt_sig = 1'b0; mem_read_sig = 1'b0; mem_wrt_sig = 1'b0;
    branch_sig = 1'b0; jump_sig = 1'b0; zf = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (state !== 3'd0 || en !== 5'b0 || pc_sel !== 2'd0 || mem_err !== 1'b0 || busy !== 1'b0 ||
        cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset: state=%0d en=%b sel=%0d err=%b busy=%b cyc=%0d ret=%0d, need all 0",
               state, en, pc_sel, mem_err, busy, cycle_cnt, retired_cnt);
    end
    $display("reset: state=%0d en=%b", state, en);
  endtask

  task automatic test_alu();
    logic [2:0] st_e [5];
    logic [4:0] en_e [5];
    st_e = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    en_e = '{5'b10000, 5'b00000, 5'b00000, 5'b01100, 5'b10000};
    do_reset();
    reg_wrt_sig = 1'b1; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (state !== st_e[c] || en !== en_e[c] || (c == 3 && pc_sel !== 2'd0)) begin
        bad++;
        $display("FAIL alu_c%0d: state=%0d en=%b sel=%0d, need state=%0d en=%b sel=0",
                 c + 1, state, en, pc_sel, st_e[c], en_e[c]);
      end
    end
    total++;
    if (retired_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
      bad++;
      $display("FAIL alu_cnt: ret=%0d cyc=%0d, need ret=1 cyc=4", retired_cnt, cycle_cnt);
    end
    $display("alu: ret=%0d cyc=%0d", retired_cnt, cycle_cnt);
  endtask

  task automatic test_load_wait();
    logic [2:0] st_e [8];
    logic [4:0] en_e [8];
    int rd_cycles = 0;
    st_e = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
    en_e = '{5'b10000, 5'b0, 5'b0, 5'b00010, 5'b00010, 5'b00010, 5'b01100, 5'b0};
    do_reset();
    mem_read_sig = 1'b1; run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == 5);
      if (c == 4) run = 1'b0;
      @(negedge clk);
      if (mem_read_en) rd_cycles++;
      total++;
      if (state !== st_e[c] || en !== en_e[c]) begin
        bad++;
        $display("FAIL load_c%0d: state=%0d en=%b, need state=%0d en=%b",
                 c + 1, state, en, st_e[c], en_e[c]);
      end
    end
    total++;
    if (rd_cycles != 3 || cycle_cnt !== 32'd7 || retired_cnt !== 32'd1) begin
      bad++;
      $display("FAIL load_sum: rd=%0d cyc=%0d ret=%0d, need rd=3 cyc=7 ret=1",
               rd_cycles, cycle_cnt, retired_cnt);
    end
    $display("load: rd=%0d cyc=%0d ret=%0d", rd_cycles, cycle_cnt, retired_cnt);
  endtask

  task automatic test_branch_jump();
    logic       br_v [3];
    logic       jp_v [3];
    logic       zf_v [3];
    logic [1:0] sel_e [3];
    logic [2:0] st_e [4];
    br_v = '{1'b1, 1'b1, 1'b1};
    jp_v = '{1'b0, 1'b0, 1'b1};
    zf_v = '{1'b1, 1'b0, 1'b1};
    sel_e = '{2'd1, 2'd0, 2'd2};
    st_e = '{3'd1, 3'd2, 3'd3, 3'd0};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      branch_sig = br_v[k]; jump_sig = jp_v[k]; zf = zf_v[k]; run = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c == 1) run = 1'b0;
        @(negedge clk);
        total++;
        if (state !== st_e[c] || (c == 2 && (en !== 5'b01000 || pc_sel !== sel_e[k]))) begin
          bad++;
          $display("FAIL br%0d_c%0d: state=%0d en=%b sel=%0d, need state=%0d (c3: en=01000 sel=%0d)",
                   k, c + 1, state, en, pc_sel, st_e[c], sel_e[k]);
        end
      end
      $display("branch case %0d: ret=%0d", k, retired_cnt);
    end
  endtask

  task automatic test_step();
    logic [2:0] st_e [5];
    logic [4:0] en_e [5];
    st_e = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    en_e = '{5'b10000, 5'b0, 5'b0, 5'b01001, 5'b0};
    do_reset();
    mem_wrt_sig = 1'b1; mem_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        step = 1'b0;
        @(negedge clk);
        total++;
        if (state !== st_e[c] || en !== en_e[c]) begin
          bad++;
          $display("FAIL step%0d_c%0d: state=%0d en=%b, need state=%0d en=%b",
                   r, c + 1, state, en, st_e[c], en_e[c]);
        end
      end
      total++;
      if (retired_cnt !== 32'(r + 1) || cycle_cnt !== 32'(4 * (r + 1))) begin
        bad++;
        $display("FAIL step%0d_cnt: ret=%0d cyc=%0d, need ret=%0d cyc=%0d",
                 r, retired_cnt, cycle_cnt, r + 1, 4 * (r + 1));
      end
      $display("step %0d: ret=%0d cyc=%0d", r, retired_cnt, cycle_cnt);
    end
  endtask

  task automatic test_timeout();
    int pc_seen = 0;
    logic [2:0] st_x;
    do_reset();
    mem_read_sig = 1'b1; run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (pc_en) pc_seen++;
      if (c >= 4) begin
        st_x = (c <= 18) ? 3'd4 : 3'd7;
        total++;
        if (state !== st_x || mem_err !== (c > 18) || mem_read_en !== (c <= 18)) begin
          bad++;
          $display("FAIL timeout_c%0d: state=%0d err=%b rd=%b, need state=%0d err=%b rd=%b",
                   c, state, mem_err, mem_read_en, st_x, c > 18, c <= 18);
        end
      end
    end
    total++;
    if (pc_seen != 0 || en !== 5'b0 || busy !== 1'b0 || cycle_cnt !== 32'd18 || retired_cnt !== 32'd0) begin
      bad++;
      $display("FAIL timeout_end: pc=%0d en=%b busy=%b cyc=%0d ret=%0d, need pc=0 en=0 busy=0 cyc=18 ret=0",
               pc_seen, en, busy, cycle_cnt, retired_cnt);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || mem_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rst: state=%0d err=%b, need state=0 err=0", state, mem_err);
    end
    rst = 1'b0;
    $display("timeout: cycles=%0d", 18);
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_read_sig = 1'b1; reg_wrt_sig = 1'b1; run = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (state !== 3'd4 || mem_read_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: state=%0d rd=%b, need state=4 rd=1", state, mem_read_en);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || en !== 5'b0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      bad++;
      $display("FAIL rstmid: state=%0d en=%b cyc=%0d ret=%0d, need all 0", state, en, cycle_cnt, retired_cnt);
    end
    rst = 1'b0;
    $display("reset mid-memory: state=%0d", state);
  endtask

  task automatic test_decode_race();
    logic [2:0] st_e [5];
    logic [4:0] en_e [5];
    st_e = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
    en_e = '{5'b10000, 5'b0, 5'b0, 5'b01100, 5'b0};
    do_reset();
    reg_wrt_sig = 1'b1; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        reg_wrt_sig = 1'b0; mem_wrt_sig = 1'b1; jump_sig = 1'b1; run = 1'b0;
      end
      @(negedge clk);
      total++;
      if (state !== st_e[c] || en !== en_e[c] || (c >= 2 && c <= 3 && pc_sel !== 2'd0)) begin
        bad++;
        $display("FAIL race_c%0d: state=%0d en=%b sel=%0d, need state=%0d en=%b sel=0",
                 c + 1, state, en, pc_sel, st_e[c], en_e[c]);
      end
    end
    // Load and store flagged together behave as a load.
    st_e = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    en_e = '{5'b10000, 5'b0, 5'b0, 5'b00010, 5'b01100};
    do_reset();
    mem_read_sig = 1'b1; mem_wrt_sig = 1'b1; mem_ready = 1'b1; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) run = 1'b0;
      @(negedge clk);
      total++;
      if (state !== st_e[c] || en !== en_e[c]) begin
        bad++;
        $display("FAIL ldst_c%0d: state=%0d en=%b, need state=%0d en=%b",
                 c + 1, state, en, st_e[c], en_e[c]);
      end
    end
    $display("decode race / load+store: ret=%0d", retired_cnt);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch_jump();
    test_step();
    test_timeout();
    test_reset_mid();
    test_decode_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, need tests to complete");
    $fatal(1);
  end

endmodule
